// File: rtl/iic_axil_master.sv
// rtl/iic_axil_master.sv - one-at-a-time command to AXI4-Lite master sequencer for the axi_iic_0 register port
// Optional IRQ latch (2-flop sync, rising-edge set, irq_clr clear) enabled by defining IIC_IRQ_LATCH_EN.
module iic_axil_master #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    input  logic [3:0]        cmd_wstrb,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_we,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [1:0]        rsp_resp,
    output logic              busy,
    output logic [ADDR_W-1:0] m_axi_awaddr,
    output logic              m_axi_awvalid,
    input  logic              m_axi_awready,
    output logic [DATA_W-1:0] m_axi_wdata,
    output logic [3:0]        m_axi_wstrb,
    output logic              m_axi_wvalid,
    input  logic              m_axi_wready,
    input  logic [1:0]        m_axi_bresp,
    input  logic              m_axi_bvalid,
    output logic              m_axi_bready,
    output logic [ADDR_W-1:0] m_axi_araddr,
    output logic              m_axi_arvalid,
    input  logic              m_axi_arready,
    input  logic [DATA_W-1:0] m_axi_rdata,
    input  logic [1:0]        m_axi_rresp,
    input  logic              m_axi_rvalid,
    output logic              m_axi_rready,
    input  logic              irq_in,
    output logic              irq_pending,
    input  logic              irq_clr
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR      = 3'd1,
        WR_RESP = 3'd2,
        RD_ADDR = 3'd3,
        RD_DATA = 3'd4,
        RSP     = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic              we_q, we_d;
    logic              aw_done_q, aw_done_d;
    logic              w_done_q, w_done_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [1:0]        resp_q, resp_d;

    // Ready is masked by rst so nothing is accepted while the core is also held in reset.
    assign cmd_ready     = (state_q == IDLE) && !rst;
    assign busy          = (state_q != IDLE);
    assign rsp_valid     = (state_q == RSP);
    assign rsp_we        = we_q;
    assign rsp_rdata     = rdata_q;
    assign rsp_resp      = resp_q;

    assign m_axi_awaddr  = addr_q;
    assign m_axi_araddr  = addr_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = wstrb_q;
    assign m_axi_awvalid = (state_q == WR) && !aw_done_q;
    assign m_axi_wvalid  = (state_q == WR) && !w_done_q;
    assign m_axi_bready  = (state_q == WR_RESP);
    assign m_axi_arvalid = (state_q == RD_ADDR);
    assign m_axi_rready  = (state_q == RD_DATA);

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        we_d      = we_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        rdata_d   = rdata_q;
        resp_d    = resp_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    addr_d    = {cmd_addr[ADDR_W-1:2], 2'b00};
                    wdata_d   = cmd_wdata;
                    wstrb_d   = cmd_wstrb;
                    we_d      = cmd_we;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = cmd_we ? WR : RD_ADDR;
                end
            end
            WR: begin
                // AW and W retire independently; leave only when both are done.
                aw_done_d = aw_done_q || (m_axi_awvalid && m_axi_awready);
                w_done_d  = w_done_q || (m_axi_wvalid && m_axi_wready);
                if (aw_done_d && w_done_d) begin
                    state_d = WR_RESP;
                end
            end
            WR_RESP: begin
                if (m_axi_bvalid) begin
                    resp_d  = m_axi_bresp;
                    rdata_d = '0;
                    state_d = RSP;
                end
            end
            RD_ADDR: begin
                if (m_axi_arready) begin
                    state_d = RD_DATA;
                end
            end
            RD_DATA: begin
                if (m_axi_rvalid) begin
                    rdata_d = m_axi_rdata;
                    resp_d  = m_axi_rresp;
                    state_d = RSP;
                end
            end
            RSP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            we_q      <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            rdata_q   <= '0;
            resp_q    <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            we_q      <= we_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            rdata_q   <= rdata_d;
            resp_q    <= resp_d;
        end
    end

`ifdef IIC_IRQ_LATCH_EN
    logic irq_s1_q, irq_s1_d;
    logic irq_s2_q, irq_s2_d;
    logic irq_prev_q, irq_prev_d;
    logic irq_pend_q, irq_pend_d;

    // A clear is applied first so a coincident edge still sets the latch.
    always_comb begin
        irq_s1_d   = irq_in;
        irq_s2_d   = irq_s1_q;
        irq_prev_d = irq_s2_q;
        irq_pend_d = irq_pend_q;
        if (irq_clr) begin
            irq_pend_d = 1'b0;
        end
        if (irq_s2_q && !irq_prev_q) begin
            irq_pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            irq_s1_q   <= 1'b0;
            irq_s2_q   <= 1'b0;
            irq_prev_q <= 1'b0;
            irq_pend_q <= 1'b0;
        end else begin
            irq_s1_q   <= irq_s1_d;
            irq_s2_q   <= irq_s2_d;
            irq_prev_q <= irq_prev_d;
            irq_pend_q <= irq_pend_d;
        end
    end

    assign irq_pending = irq_pend_q;
`else
    logic unused_irq;
    assign unused_irq  = irq_in ^ irq_clr;
    assign irq_pending = 1'b0;
`endif

endmodule

// File: doc/iic_axil_master.md
Name: iic_axil_master

Overview:
- AXI4-Lite master sequencer directly upstream of the axi_iic_0 core; converts a simple one-at-a-time register command stream (write/read, address, data) into AXI4-Lite transactions on the core's s_axi_* slave port.
- Returns write response or read data on a response channel.
- Used by higher-level I2C control logic (init sequencers, test harness) so it never drives AXI handshakes directly.

Parameters:
- ADDR_W, 9, AXI address width; matches the core's s_axi_awaddr/araddr.
- DATA_W, 32, AXI data width; fixed at 32 (byte-lane logic assumes 4 lanes).

Ports:
- clk  in  1  single clock; also drives the core's s_axi_aclk.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
- cmd_we  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  byte address; bits [1:0] forced to 0 on the bus.
- cmd_wdata  in  DATA_W  write data.
- cmd_wstrb  in  4  write byte strobes.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed when rsp_valid & rsp_ready.
- rsp_we  out  1  echo of cmd_we for this response.
- rsp_rdata  out  DATA_W  read data; 0 for writes.
- rsp_resp  out  2  captured BRESP or RRESP.
- busy  out  1  high whenever state != IDLE.
- m_axi_awaddr/awvalid/awready, wdata/wstrb/wvalid/wready, bresp/bvalid/bready, araddr/arvalid/arready, rdata/rresp/rvalid/rready  AXI4-Lite master; widths ADDR_W, DATA_W, 4, 2 as per AXI4-Lite.
- irq_in  in  1  iic2intc_irpt from the core.
- irq_pending  out  1  see Optional Feature.
- irq_clr  in  1  see Optional Feature.

Behaviour:
- Reset: state IDLE. All AXI valid/ready outputs 0. cmd_ready 0 during reset, 1 from the first cycle after rst deasserts. rsp_valid 0, rsp_rdata 0, rsp_resp 0, rsp_we 0, busy 0, irq_pending 0.
- rst asserted mid-transaction: all outputs return to reset values the next cycle. In-flight transaction is abandoned with no response. The team resets the core concurrently.
- States: IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, RSP.
- IDLE:
  - cmd_ready = 1.
  - On accept, register addr (low 2 bits zeroed), wdata, wstrb and we.
  - Go to WR if we, else RD_ADDR.
  - First AXI valid is driven the cycle after accept.
- WR:
  - awvalid and wvalid asserted together.
  - Each drops the cycle after its own handshake; AW and W may complete in either order or the same cycle.
  - Exit to WR_RESP once both have completed.
  - Valid and payload stay stable until handshake (no withdrawal).
- WR_RESP: bready = 1. On bvalid, capture bresp into rsp_resp, clear rsp_rdata, go to RSP.
- RD_ADDR: arvalid = 1 with stable araddr. On arready, go to RD_DATA.
- RD_DATA: rready = 1. On rvalid, capture rdata/rresp, go to RSP.
- RSP:
  - rsp_valid = 1, payload stable.
  - On rsp_ready, go to IDLE; cmd_ready is 1 the following cycle (no command accepted in the same cycle as the response).
- Only one outstanding transaction at a time. Ready-before-valid slaves are supported.
- Minimum latency, accept to rsp_valid, with zero-wait slave:
  - Write: 3 cycles (issue, B, RSP).
  - Read: 3 cycles (AR, R, RSP).
- Non-OKAY responses (SLVERR/DECERR) are passed through unchanged; no retry.
- busy = (state != IDLE).

Optional Feature:
- Macro: IIC_IRQ_LATCH_EN.
- Defined:
  - irq_in passes through a 2-flop synchronizer plus rising-edge detect.
  - A detected edge sets irq_pending; irq_clr clears it.
  - Simultaneous edge and clear: set wins.
  - irq_pending resets to 0.
- Undefined: irq_pending is tied to 0 and irq_in/irq_clr are ignored (no flops inferred).

Test Plan:
- Zero-wait write: cmd we=1 addr=0x100 wdata=0x00000001 wstrb=0xF -> awaddr=0x100 and wdata=0x1 with awvalid/wvalid in the same cycle; rsp_valid 3 cycles after accept with rsp_resp=0, rsp_we=1, rsp_rdata=0.
- Read with wait states: cmd we=0 addr=0x104; slave holds arready low 4 cycles, then returns rdata=0x000000C0 after 2 more cycles -> araddr stable throughout; rsp_rdata=0xC0, rsp_resp=0.
- Split AW/W: wready arrives 3 cycles before awready -> wvalid drops after its handshake, awvalid held; single B accepted; one response only.
- Error plus backpressure: bresp=2'b10 with rsp_ready held low 5 cycles -> rsp_valid and rsp_resp=2'b10 held stable; cmd_ready stays 0 until the cycle after rsp_ready.
- Unaligned address and reset mid-read: cmd addr=0x10B drives araddr=0x108; rst asserted while in RD_DATA -> next cycle all valids 0, rsp_valid 0, cmd_ready 0, then cmd_ready 1 after rst drops.
- With IIC_IRQ_LATCH_EN: irq_in rises -> irq_pending=1 three cycles later; irq_clr on the same cycle as a new edge -> irq_pending stays 1. Without the macro: irq_pending is always 0.
